// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [0:0] {
        PRIO_CORE = 1'b0,
        PRIO_DBG  = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_id_t;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    // Wide enough for the largest legal starvation limit (255).
    localparam int CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Core, debug and data-memory bus bundle for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if;

    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [1:0]  core_mask;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [1:0]  dbg_mask;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_data_mask;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_read_data;

    // Arbiter view.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_mask,
        output core_gnt, core_rvalid, core_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_mask,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_write_data, mem_data_mask, mem_write_en, mem_read_en,
        input  mem_read_data
    );

    // Requester / memory view.
    modport master (
        output core_req, core_we, core_addr, core_wdata, core_mask,
        input  core_gnt, core_rvalid, core_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_mask,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_write_data, mem_data_mask, mem_write_en, mem_read_en,
        output mem_read_data
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_starve_ctr.sv
// ============================================================================
// Module      : dmem_arb_starve_ctr
// Description : Debug wait counter and tie-break priority FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_dbg_req,
    input  wire logic i_dbg_gnt,
    output arb_state_t o_state
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    arb_state_t       r_state;

    always_comb begin
        w_cnt_next = r_wait_cnt;
        if (!i_dbg_req || i_dbg_gnt) begin
            w_cnt_next = '0;
        end else if (r_wait_cnt != C_LIMIT) begin
            w_cnt_next = r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PRIO_CORE;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_cnt_next;
            case (r_state)
                PRIO_CORE: if (w_cnt_next == C_LIMIT) r_state <= PRIO_DBG;
                // Held until debug actually wins, even if it stops asking.
                PRIO_DBG:  if (i_dbg_gnt) r_state <= PRIO_CORE;
                default:   r_state <= PRIO_CORE;
            endcase
        end
    end

    assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port (core/debug) arbiter onto a single data memory.
//               Build option DMEM_ARB_STARVE_EN enables debug anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    dmem_arbiter_if.slave bus
);

    arb_state_t w_state;
    logic       w_core_gnt;
    logic       w_dbg_gnt;
    logic       r_rd_valid;
    port_id_t   r_rd_port;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_dbg_req (bus.dbg_req),
        .i_dbg_gnt (w_dbg_gnt),
        .o_state   (w_state)
    );
`else
    localparam logic [7:0] C_LIMIT_BITS = 8'(STARVE_LIMIT);
    logic w_unused_limit;

    assign w_state        = PRIO_CORE;
    assign w_unused_limit = ^C_LIMIT_BITS;
`endif

    // Core wins unless debug holds priority and is also asking.
    assign w_core_gnt = !rst && bus.core_req && (!bus.dbg_req || (w_state == PRIO_CORE));
    assign w_dbg_gnt  = !rst && bus.dbg_req && !w_core_gnt;

    assign bus.core_gnt = w_core_gnt;
    assign bus.dbg_gnt  = w_dbg_gnt;

    assign bus.mem_addr       = w_dbg_gnt ? bus.dbg_addr  : bus.core_addr;
    assign bus.mem_write_data = w_dbg_gnt ? bus.dbg_wdata : bus.core_wdata;
    assign bus.mem_data_mask  = w_dbg_gnt ? bus.dbg_mask  : bus.core_mask;
    assign bus.mem_write_en   = (w_core_gnt && bus.core_we)  || (w_dbg_gnt && bus.dbg_we);
    assign bus.mem_read_en    = (w_core_gnt && !bus.core_we) || (w_dbg_gnt && !bus.dbg_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_port  <= PORT_CORE;
        end else begin
            r_rd_valid <= bus.mem_read_en;
            r_rd_port  <= w_dbg_gnt ? PORT_DBG : PORT_CORE;
        end
    end

    // Gating with rst drops a read whose data would land in a reset cycle.
    assign bus.core_rvalid = r_rd_valid && (r_rd_port == PORT_CORE) && !rst;
    assign bus.dbg_rvalid  = r_rd_valid && (r_rd_port == PORT_DBG)  && !rst;
    assign bus.core_rdata  = bus.mem_read_data;
    assign bus.dbg_rdata   = bus.mem_read_data;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        port_id_t    port;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      n_pass  = 0;
    int      n_fail  = 0;
    int      n_total = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h40) ? 32'h1234_5678 : (a ^ 32'hC0DE_0000);
    endfunction

    // Memory model: data one cycle after a read enable.
    always_ff @(posedge clk) begin
        if (bus.mem_read_en) bus.mem_read_data <= mem_f(bus.mem_addr);
    end

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    task automatic set_core(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] mask);
        bus.core_req = req; bus.core_we = we; bus.core_addr = addr;
        bus.core_wdata = wdata; bus.core_mask = mask;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] mask);
        bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr;
        bus.dbg_wdata = wdata; bus.dbg_mask = mask;
    endtask

    // One clock: check outputs at negedge, then advance to just after posedge.
    task automatic step(input string tag, input bit eg_core, input bit eg_dbg);
        rd_exp_t e;
        logic    exp_crv;
        logic    exp_drv;
        @(negedge clk);
        exp_crv = 1'b0;
        exp_drv = 1'b0;
        e = '{PORT_CORE, 32'h0};
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!rst) begin
                if (e.port == PORT_CORE) exp_crv = 1'b1;
                else                     exp_drv = 1'b1;
            end
        end
        chk(tag, "core_rvalid", 32'(bus.core_rvalid), 32'(exp_crv));
        chk(tag, "dbg_rvalid",  32'(bus.dbg_rvalid),  32'(exp_drv));
        if (exp_crv) chk(tag, "core_rdata", bus.core_rdata, e.data);
        if (exp_drv) chk(tag, "dbg_rdata",  bus.dbg_rdata,  e.data);
        chk(tag, "core_gnt", 32'(bus.core_gnt), 32'(eg_core));
        chk(tag, "dbg_gnt",  32'(bus.dbg_gnt),  32'(eg_dbg));
        if (eg_core) begin
            chk(tag, "mem_addr", bus.mem_addr, bus.core_addr);
            chk(tag, "mem_write_en", 32'(bus.mem_write_en), 32'(bus.core_we));
            chk(tag, "mem_read_en",  32'(bus.mem_read_en),  32'(!bus.core_we));
            if (bus.core_we) begin
                chk(tag, "mem_write_data", bus.mem_write_data, bus.core_wdata);
                chk(tag, "mem_data_mask",  32'(bus.mem_data_mask), 32'(bus.core_mask));
            end else begin
                sb.push_back('{PORT_CORE, mem_f(bus.core_addr)});
            end
        end else if (eg_dbg) begin
            chk(tag, "mem_addr", bus.mem_addr, bus.dbg_addr);
            chk(tag, "mem_write_en", 32'(bus.mem_write_en), 32'(bus.dbg_we));
            chk(tag, "mem_read_en",  32'(bus.mem_read_en),  32'(!bus.dbg_we));
            if (bus.dbg_we) begin
                chk(tag, "mem_write_data", bus.mem_write_data, bus.dbg_wdata);
                chk(tag, "mem_data_mask",  32'(bus.mem_data_mask), 32'(bus.dbg_mask));
            end else begin
                sb.push_back('{PORT_DBG, mem_f(bus.dbg_addr)});
            end
        end else begin
            chk(tag, "mem_write_en", 32'(bus.mem_write_en), 32'd0);
            chk(tag, "mem_read_en",  32'(bus.mem_read_en),  32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both requesters active: nothing may be granted.
        rst = 1'b1;
        set_core(1'b1, 1'b0, 32'h10, 32'h0, MASK_WORD);
        set_dbg (1'b1, 1'b0, 32'h20, 32'h0, MASK_WORD);
        step("reset0", 1'b0, 1'b0);
        step("reset1", 1'b0, 1'b0);
        rst = 1'b0;

        // Core-only word write, granted in the first cycle out of reset.
        set_dbg (1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        set_core(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, MASK_WORD);
        step("core_wr", 1'b1, 1'b0);

        // Debug read with known memory contents.
        set_core(1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        set_dbg (1'b1, 1'b0, 32'h40, 32'h0, MASK_WORD);
        step("dbg_rd", 1'b0, 1'b1);
        set_dbg (1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        step("dbg_rd_done", 1'b0, 1'b0);

        // Back-to-back single-requester traffic, alternating ports.
        set_core(1'b1, 1'b0, 32'h200, 32'h0, MASK_HALF);
        step("b2b_core_rd", 1'b1, 1'b0);
        set_core(1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        set_dbg (1'b1, 1'b0, 32'h300, 32'h0, MASK_BYTE);
        step("b2b_dbg_rd", 1'b0, 1'b1);
        set_dbg (1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        set_core(1'b1, 1'b1, 32'h204, 32'h0BAD_F00D, MASK_HALF);
        step("b2b_core_wr", 1'b1, 1'b0);
        set_core(1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        set_dbg (1'b1, 1'b1, 32'h304, 32'h5555_AAAA, MASK_BYTE);
        step("b2b_dbg_wr", 1'b0, 1'b1);
        set_dbg (1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        set_core(1'b1, 1'b0, 32'h208, 32'h0, MASK_WORD);
        step("b2b_core_rd2", 1'b1, 1'b0);
        set_core(1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        step("idle0", 1'b0, 1'b0);

        // Continuous contention: debug wins every fifth cycle only with starvation guard.
        set_core(1'b1, 1'b0, 32'h500, 32'h0, MASK_WORD);
        set_dbg (1'b1, 1'b0, 32'h600, 32'h0, MASK_WORD);
        for (int i = 0; i < 12; i++) begin
            step("contend", !(STARVE && (i % 5 == 4)), STARVE && (i % 5 == 4));
        end
        set_core(1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        set_dbg (1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        step("idle1", 1'b0, 1'b0);

        // A one-cycle drop of dbg_req restarts the wait count.
        set_core(1'b1, 1'b1, 32'h700, 32'h1111_2222, MASK_WORD);
        set_dbg (1'b1, 1'b0, 32'h704, 32'h0, MASK_WORD);
        for (int i = 0; i < 3; i++) step("wait3", 1'b1, 1'b0);
        bus.dbg_req = 1'b0;
        step("dbg_drop", 1'b1, 1'b0);
        bus.dbg_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("fresh_wait", !(STARVE && i == 4), STARVE && i == 4);
        end

        // Promoted debug keeps priority across a cycle in which it stops asking.
        for (int i = 0; i < 4; i++) step("promote", 1'b1, 1'b0);
        bus.dbg_req = 1'b0;
        step("prio_hold_lone", 1'b1, 1'b0);
        bus.dbg_req = 1'b1;
        step("prio_hold_tie", !STARVE, STARVE);
        set_core(1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        set_dbg (1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        step("idle2", 1'b0, 1'b0);

        // Reset right after a granted core read, with the wait count part-way up.
        set_core(1'b1, 1'b0, 32'h800, 32'h0, MASK_WORD);
        set_dbg (1'b1, 1'b0, 32'h900, 32'h0, MASK_WORD);
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0);
        rst = 1'b1;
        step("mid_rst", 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("post_rst", !(STARVE && i == 4), STARVE && i == 4);
        end
        set_core(1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        set_dbg (1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE);
        step("drain0", 1'b0, 1'b0);
        step("drain1", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive debug wait cycles before debug is promoted (legal 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 core_req, core_we  input  1 each  core request valid, and write (1) / read (0).
REQ-005 core_addr, core_wdata  input  32 each  core byte address and write data.
REQ-006 core_mask  input  2  core access size (00 byte, 01 half, 10 word).
REQ-007 core_gnt, core_rvalid  output  1 each  core request accepted this cycle, and core read data valid.
REQ-008 core_rdata  output  32  core read data.
REQ-009 dbg_* SHALL have the same eight signals as REQ-004..008 for the debug/loader requester.
REQ-010 mem_addr, mem_write_data  output  32 each  to data memory.
REQ-011 mem_data_mask  output  2  to data memory.
REQ-012 mem_write_en, mem_read_en  output  1 each  to data memory.
REQ-013 mem_read_data  input  32  from data memory, valid one cycle after mem_read_en.

Function
REQ-014 SHALL grant at most one requester per cycle; gnt is combinational from req and state.
REQ-015 SHALL drive mem_* from the granted requester's addr/wdata/mask; mem_write_en = gnt&we; mem_read_en = gnt&!we.
REQ-016 With no grant, mem_write_en and mem_read_en SHALL be 0; mem_addr/data/mask are don't-care.
REQ-017 A requester SHALL hold req, addr, wdata, mask and we stable until gnt; a write completes in its grant cycle.
REQ-018 For a granted read, the arbiter SHALL assert that port's rvalid exactly one cycle later, with rdata = mem_read_data; the other port's rvalid SHALL stay 0.
REQ-019 rdata of a port without rvalid is don't-care.
REQ-020 Back-to-back grants (either port, every cycle) SHALL be supported with no bubble.
REQ-021 FSM states: PRIO_CORE (core wins ties) and PRIO_DBG (debug wins ties); a lone requester is always granted.
REQ-022 wait_cnt SHALL increment each cycle with dbg_req=1 and dbg_gnt=0, saturating at STARVE_LIMIT.
REQ-023 wait_cnt SHALL clear on dbg_gnt, or on any cycle with dbg_req=0.
REQ-024 PRIO_CORE -> PRIO_DBG on the edge where wait_cnt reaches STARVE_LIMIT.
REQ-025 PRIO_DBG -> PRIO_CORE on the edge following one dbg grant.
REQ-026 PRIO_DBG SHALL be held while debug is not granted, including when dbg_req drops.

Reset
REQ-027 While rst=1: all gnt, rvalid, mem_write_en and mem_read_en SHALL be 0; state <= PRIO_CORE; wait_cnt <= 0; pending-read tag cleared.
REQ-028 A read granted in the cycle before rst asserts SHALL NOT produce rvalid.
REQ-029 First grant is possible in the first cycle with rst=0.

Configuration
REQ-030 DMEM_ARB_STARVE_EN defined: REQ-022..026 apply.
REQ-031 DMEM_ARB_STARVE_EN undefined: strict core priority; FSM fixed at PRIO_CORE; wait_cnt absent; STARVE_LIMIT ignored.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold arb_state_t (PRIO_CORE, PRIO_DBG), port_id_t (PORT_CORE, PORT_DBG) and mask constants MASK_BYTE/HALF/WORD.
REQ-033 Starvation counter plus FSM SHALL be sub-module dmem_arb_starve_ctr, instantiated only under DMEM_ARB_STARVE_EN.

Verification
REQ-034 Core-only write: addr 0x100, wdata 0xDEADBEEF, mask 10 -> core_gnt same cycle; mem_write_en=1 with those values; no rvalid.
REQ-035 Debug read 0x40 with mem returning 0x12345678 -> dbg_gnt; mem_read_en=1; next cycle dbg_rvalid=1, dbg_rdata=0x12345678, core_rvalid=0.
REQ-036 STARVE_EN, STARVE_LIMIT=4, both ports request continuously -> core granted 4 cycles, dbg granted cycle 5, core granted cycle 6; pattern repeats.
REQ-037 Same stimulus, macro undefined -> dbg_gnt never asserts while core_req=1.
REQ-038 rst pulsed the cycle after a granted core read -> no core_rvalid; state PRIO_CORE; wait_cnt=0.
REQ-039 dbg_req held 3 cycles under LIMIT=4, dropped 1 cycle, then reasserted -> promotion requires 4 fresh wait cycles.
